// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared encodings for the IF/D memory port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  localparam int WE_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : core-side request ports and memory-side handshake
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [WE_W-1:0]   d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [WE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_addr, mem_we, mem_wdata, err
  );

  // Core + memory side
  modport master (
    output if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_addr, mem_we, mem_wdata, err
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_rr_arb2 : two-way round-robin picker, IF favoured last
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   req_if,
  input  logic   req_d,
  output logic   gnt_if,
  output logic   gnt_d,
  output owner_e winner
);

  owner_e last_owner_q;
  owner_e last_owner_d;

  // On a tie, whoever did not win last time goes first.
  always_comb begin
    if (req_if && req_d) begin
      winner = (last_owner_q == OWNER_IF) ? OWNER_D : OWNER_IF;
    end else if (req_d) begin
      winner = OWNER_D;
    end else begin
      winner = OWNER_IF;
    end
    gnt_if       = en && req_if && (winner == OWNER_IF);
    gnt_d        = en && req_d && (winner == OWNER_D);
    last_owner_d = (gnt_if || gnt_d) ? winner : last_owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWNER_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one variable-latency memory between IF and D ports
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter int                CNT_W    = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              mem_req_q, mem_req_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic              arb_gnt_if;
  logic              arb_gnt_d;
  owner_e            arb_winner;
  logic              timed_out;
  logic [DATA_W-1:0] resp_data;

  mem_port_arbiter_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_IDLE),
    .req_if (bus.if_req),
    .req_d  (bus.d_req),
    .gnt_if (arb_gnt_if),
    .gnt_d  (arb_gnt_d),
    .winner (arb_winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    // The watchdog reads k in the k-th BUSY cycle, so TIMEOUT bounds mem_req cycles.
    timed_out   = (wdog_q == CNT_W'(TIMEOUT));
    resp_data   = bus.mem_ack ? ((we_q != '0) ? '0 : bus.mem_rdata) : ERR_DATA;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt_if || arb_gnt_d) begin
          owner_d   = arb_winner;
          addr_d    = arb_gnt_d ? bus.d_addr : bus.if_addr;
          we_d      = arb_gnt_d ? bus.d_we : '0;
          wdata_d   = arb_gnt_d ? bus.d_wdata : '0;
          wdog_d    = CNT_W'(1);
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack || timed_out) begin
          err_d     = err_q | ~bus.mem_ack;
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (owner_q == OWNER_D) begin
            d_rdata_d  = resp_data;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = resp_data;
            if_rvalid_d = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RESP: begin
        wdog_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.if_gnt    = arb_gnt_if;
  assign bus.d_gnt     = arb_gnt_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : vector table, corner sequences and random model check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(8), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          alat = 0;
  int          busy_cnt = 0;
  bit          spurious = 1'b0;
  logic [31:0] mword = '0;

  typedef struct {
    bit rif; bit rd;
    logic [31:0] ia; logic [31:0] da; logic [3:0] we; logic [31:0] wd;
    int alat; logic [31:0] mword;
    int ewin; logic [31:0] eaddr; logic [3:0] ewe; logic [31:0] ewd;
    int enreq; int elat; logic [31:0] erd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One clock; the memory responder acks on the alat-th mem_req cycle (0 = never).
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.mem_req) begin
      busy_cnt++;
      bus.mem_ack = (alat != 0) && (busy_cnt == alat);
    end else begin
      busy_cnt = 0;
      bus.mem_ack = spurious && ($urandom_range(0, 3) == 0);
    end
    bus.mem_rdata = bus.mem_ack ? mword : $urandom;
    @(negedge clk);
  endtask

  // One full access from the next IDLE cycle; reports what was observed.
  task automatic access(input bit rif, input bit rd, output int win,
                        output logic [31:0] maddr, output logic [3:0] mwe,
                        output logic [31:0] mwd, output int nreq, output int lat,
                        output int who, output logic [31:0] rdat);
    cycle();
    bus.if_req = rif;
    bus.d_req  = rd;
    #1;
    win = -1;
    if (bus.if_gnt && bus.d_gnt) win = 2;
    else if (bus.d_gnt) win = 1;
    else if (bus.if_gnt) win = 0;
    maddr = '0; mwe = '0; mwd = '0; nreq = 0; lat = -1; who = -1; rdat = '0;
    for (int c = 1; c <= 40; c++) begin
      cycle();
      if (c == 1) begin
        maddr = bus.mem_addr;
        mwe   = bus.mem_we;
        mwd   = bus.mem_wdata;
        if (win == 0 || win == 2) bus.if_req = 1'b0;
        if (win == 1 || win == 2) bus.d_req = 1'b0;
      end
      if (bus.mem_req) nreq++;
      if (bus.if_rvalid || bus.d_rvalid) begin
        lat  = c;
        who  = (bus.if_rvalid && bus.d_rvalid) ? 2 : (bus.d_rvalid ? 1 : 0);
        rdat = bus.d_rvalid ? bus.d_rdata : bus.if_rdata;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t        tbl[6];
    int          win, nreq, lat, who;
    logic [31:0] maddr, mwd, rdat;
    logic [3:0]  mwe;
    bit          seen;
    int          last_m, exp_win, exp_nreq;
    bit          err_m, pend_if, pend_d, rif, rd, tmo;
    logic [31:0] exp_addr, exp_rd;
    logic [3:0]  exp_we;

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_addr = '0;
    bus.d_we = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;

    tbl[0] = '{1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 3, 32'h2008_0005,
               0, 32'h40, 4'h0, 32'h0, 3, 4, 32'h2008_0005};
    tbl[1] = '{0, 1, 32'h0, 32'h101, 4'b0100, 32'h00AB_0000, 2, 32'h1234_5678,
               1, 32'h101, 4'b0100, 32'h00AB_0000, 2, 3, 32'h0};
    tbl[2] = '{0, 1, 32'h0, 32'h200, 4'h0, 32'h0, 1, 32'hCAFE_F00D,
               1, 32'h200, 4'h0, 32'h0, 1, 2, 32'hCAFE_F00D};
    tbl[3] = '{1, 1, 32'h80, 32'h300, 4'h0, 32'h0, 2, 32'h1111_2222,
               0, 32'h80, 4'h0, 32'h0, 2, 3, 32'h1111_2222};
    tbl[4] = '{0, 1, 32'h80, 32'h300, 4'h0, 32'h0, 1, 32'h0BAD_F00D,
               1, 32'h300, 4'h0, 32'h0, 1, 2, 32'h0BAD_F00D};
    tbl[5] = '{1, 0, 32'h84, 32'h300, 4'h0, 32'h0, 4, 32'h5A5A_A5A5,
               0, 32'h84, 4'h0, 32'h0, 4, 5, 32'h5A5A_A5A5};

    // Reset state
    cycle();
    cycle();
    chk("rst_ctrl", {26'd0, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                     bus.mem_req, bus.err}, 32'h0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_we", {28'd0, bus.mem_we}, 32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seen |= bus.mem_req;
    end
    chk("idle_mem_req", {31'd0, seen}, 32'h0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      bus.if_addr = tbl[i].ia;
      bus.d_addr  = tbl[i].da;
      bus.d_we    = tbl[i].we;
      bus.d_wdata = tbl[i].wd;
      alat        = tbl[i].alat;
      mword       = tbl[i].mword;
      access(tbl[i].rif, tbl[i].rd, win, maddr, mwe, mwd, nreq, lat, who, rdat);
      chk($sformatf("v%0d_winner", i), win, tbl[i].ewin);
      chk($sformatf("v%0d_mem_addr", i), maddr, tbl[i].eaddr);
      chk($sformatf("v%0d_mem_we", i), {28'd0, mwe}, {28'd0, tbl[i].ewe});
      if (tbl[i].ewin == 1) chk($sformatf("v%0d_mem_wdata", i), mwd, tbl[i].ewd);
      chk($sformatf("v%0d_mem_req_cycles", i), nreq, tbl[i].enreq);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].elat);
      chk($sformatf("v%0d_rvalid_owner", i), who, tbl[i].ewin);
      chk($sformatf("v%0d_rdata", i), rdat, tbl[i].erd);
    end
    chk("ack_on_timeout_cycle_err", {31'd0, bus.err}, 32'h0);

    // Four back-to-back ties after reset: D, IF, D, IF
    do_reset();
    alat = 1;
    mword = 32'h7777_0000;
    bus.if_addr = 32'h10; bus.d_addr = 32'h20; bus.d_we = '0;
    for (int i = 0; i < 4; i++) begin
      access(1, 1, win, maddr, mwe, mwd, nreq, lat, who, rdat);
      chk($sformatf("tie%0d_winner", i), win, (i % 2 == 0) ? 1 : 0);
    end
    access(0, 1, win, maddr, mwe, mwd, nreq, lat, who, rdat);
    chk("tie_drain_winner", win, 1);

    // Watchdog abort, then err stays set across a good access
    alat = 0;
    bus.d_addr = 32'h44; bus.d_we = '0;
    access(0, 1, win, maddr, mwe, mwd, nreq, lat, who, rdat);
    chk("tmo_mem_req_cycles", nreq, TMO);
    chk("tmo_latency", lat, TMO + 1);
    chk("tmo_rvalid_owner", who, 1);
    chk("tmo_rdata", rdat, 32'hDEAD_BEEF);
    chk("tmo_err", {31'd0, bus.err}, 32'h1);
    alat = 2;
    mword = 32'h0000_1234;
    access(1, 0, win, maddr, mwe, mwd, nreq, lat, who, rdat);
    chk("post_tmo_rdata", rdat, 32'h0000_1234);
    chk("post_tmo_err_sticky", {31'd0, bus.err}, 32'h1);

    // Reset in the middle of BUSY
    alat = 0;
    cycle();
    bus.d_req = 1'b1;
    cycle();
    bus.d_req = 1'b0;
    cycle();
    chk("midrst_busy", {31'd0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req_async", {31'd0, bus.mem_req}, 32'h0);
    chk("midrst_err_cleared", {31'd0, bus.err}, 32'h0);
    cycle();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      seen |= bus.if_rvalid | bus.d_rvalid | bus.mem_req;
    end
    chk("midrst_no_activity", {31'd0, seen}, 32'h0);

    // Randomized traffic against a behavioural model
    do_reset();
    spurious = 1'b1;
    last_m = 0; err_m = 0; pend_if = 0; pend_d = 0;
    for (int n = 0; n < 150; n++) begin
      rif = pend_if | 1'($urandom_range(0, 1));
      rd  = pend_d | 1'($urandom_range(0, 1));
      if (!rif && !rd) rif = 1'b1;
      if (!pend_if) bus.if_addr = $urandom & 32'hFFFF_FFFC;
      if (!pend_d) begin
        bus.d_addr  = $urandom;
        bus.d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        bus.d_wdata = $urandom;
      end
      alat  = $urandom_range(0, TMO + 2);
      mword = $urandom;

      exp_win  = (rif && rd) ? ((last_m == 0) ? 1 : 0) : (rd ? 1 : 0);
      exp_addr = (exp_win == 1) ? bus.d_addr : bus.if_addr;
      exp_we   = (exp_win == 1) ? bus.d_we : 4'h0;
      tmo      = (alat == 0) || (alat > TMO);
      exp_nreq = tmo ? TMO : alat;
      exp_rd   = tmo ? 32'hDEAD_BEEF : ((exp_we != 4'h0) ? 32'h0 : mword);
      err_m    = err_m | tmo;

      access(rif, rd, win, maddr, mwe, mwd, nreq, lat, who, rdat);
      chk($sformatf("r%0d_winner", n), win, exp_win);
      chk($sformatf("r%0d_mem_addr", n), maddr, exp_addr);
      chk($sformatf("r%0d_mem_we", n), {28'd0, mwe}, {28'd0, exp_we});
      chk($sformatf("r%0d_mem_req_cycles", n), nreq, exp_nreq);
      chk($sformatf("r%0d_latency", n), lat, exp_nreq + 1);
      chk($sformatf("r%0d_rvalid_owner", n), who, exp_win);
      chk($sformatf("r%0d_rdata", n), rdat, exp_rd);
      chk($sformatf("r%0d_err", n), {31'd0, bus.err}, {31'd0, err_m});

      last_m  = exp_win;
      pend_if = rif && (exp_win == 1);
      pend_d  = rd && (exp_win == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
